// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
//
// Consumes a length-prefixed byte stream and writes the payload into
// instruction memory one byte per cycle. The frame format is:
//   length low byte, length high byte (16-bit little-endian N), N payload bytes,
//   and one XOR checksum byte.
// The CPU is held stalled until a frame has been written and its checksum verified.
//
// Ports:
//   clk_i        single clock; all state changes on the rising edge
//   rst_n_i      asynchronous active-low reset
//   start_i      re-arm pulse; acted on only in the done or error state
//   ld_valid_i   loader stream valid
//   ld_data_i    loader stream data byte
//   ld_ready_o   loader stream ready
//   wr_en_o      imem byte write enable (registered, one cycle per accepted payload byte)
//   wr_addr_o    imem byte address
//   wr_data_o    imem byte data
//   load_done_o  frame loaded and checksum good
//   load_err_o   frame aborted
//   err_code_o   00 none, 01 length too large, 10 checksum mismatch
//   cpu_stall_o  freezes fetch/pipeline; inverse of load_done_o
//   byte_cnt_o   payload bytes written so far
module imem_loader #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_data_i,
    output logic        ld_ready_o,
    output logic        wr_en_o,
    output logic [9:0]  wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        load_done_o,
    output logic        load_err_o,
    output logic [1:0]  err_code_o,
    output logic        cpu_stall_o,
    output logic [10:0] byte_cnt_o
);

    typedef enum logic [2:0] {
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [1:0]  ErrNone   = 2'b00;
    localparam logic [1:0]  ErrLen    = 2'b01;
    localparam logic [1:0]  ErrCsum   = 2'b10;
    // One bit wider than the 16-bit length so that MEM_BYTES = 65536 still compares correctly.
    localparam logic [16:0] MemBytesW = 17'(MEM_BYTES);

    state_e      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  csum_q, csum_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        accept;
    logic [15:0] len_full;
    logic [10:0] cnt_inc;

    // Ready depends only on the state, so a stalled stream can never change anything.
    always_comb begin
        ld_ready_o = 1'b0;
        unique case (state_q)
            StLenLo, StLenHi, StData, StCsum: ld_ready_o = 1'b1;
            default:                          ld_ready_o = 1'b0;
        endcase
    end

    assign accept   = ld_valid_i & ld_ready_o;
    assign len_full = {ld_data_i, len_lo_q};
    assign cnt_inc  = byte_cnt_q + 11'd1;

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        csum_d     = csum_q;
        byte_cnt_d = byte_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        unique case (state_q)
            StLenLo: begin
                if (accept) begin
                    len_lo_d = ld_data_i;
                    state_d  = StLenHi;
                end
            end

            StLenHi: begin
                if (accept) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > MemBytesW) begin
                        // Oversized frame: abort before any byte reaches memory.
                        state_d    = StErr;
                        err_d      = 1'b1;
                        err_code_d = ErrLen;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end

            StData: begin
                if (accept) begin
                    wr_en_d    = 1'b1;
                    // N <= MEM_BYTES, so byte_cnt_q is at most MEM_BYTES-1 here and cannot wrap.
                    wr_addr_d  = byte_cnt_q[9:0];
                    wr_data_d  = ld_data_i;
                    csum_d     = csum_q ^ ld_data_i;
                    byte_cnt_d = cnt_inc;
                    if ({5'd0, cnt_inc} == len_q) begin
                        state_d = StCsum;
                    end
                end
            end

            StCsum: begin
                if (accept) begin
                    if (ld_data_i == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        // Bytes already written are left in memory.
                        state_d    = StErr;
                        err_d      = 1'b1;
                        err_code_d = ErrCsum;
                    end
                end
            end

            StDone, StErr: begin
                if (start_i) begin
                    state_d    = StLenLo;
                    len_lo_d   = 8'd0;
                    len_d      = 16'd0;
                    csum_d     = 8'd0;
                    byte_cnt_d = 11'd0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ErrNone;
                end
            end

            default: state_d = StLenLo;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StLenLo;
            len_lo_q   <= 8'd0;
            len_q      <= 16'd0;
            csum_q     <= 8'd0;
            byte_cnt_q <= 11'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 10'd0;
            wr_data_q  <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign load_done_o = done_q;
    assign load_err_o  = err_q;
    assign err_code_o  = err_code_q;
    assign cpu_stall_o = ~done_q;
    assign byte_cnt_o  = byte_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;
    logic        cpu_stall;
    logic [10:0] byte_cnt;

    int checks   = 0;
    int failures = 0;

    imem_loader #(
        .MEM_BYTES(1024)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .ld_valid_i  (ld_valid),
        .ld_data_i   (ld_data),
        .ld_ready_o  (ld_ready),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .load_done_o (load_done),
        .load_err_o  (load_err),
        .err_code_o  (err_code),
        .cpu_stall_o (cpu_stall),
        .byte_cnt_o  (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus plus the outputs expected just after that edge.
    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        wen;
        logic [9:0]  addr;
        logic [7:0]  wd;
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic [10:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic v, input logic [7:0] d, input logic rdy,
                       input logic wen, input logic [9:0] addr, input logic [7:0] wd,
                       input logic done, input logic err, input logic [1:0] code,
                       input logic [10:0] cnt);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.rdy = rdy; r.wen = wen; r.addr = addr; r.wd = wd;
        r.done = done; r.err = err; r.code = code; r.cnt = cnt;
        tbl.push_back(r);
    endtask

    task automatic step(input logic st, input logic v, input logic [7:0] d);
        @(negedge clk);
        start    = st;
        ld_valid = v;
        ld_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Address/data are only compared when a write is expected.
    task automatic check_out(input string name, input logic rdy, input logic wen,
                             input logic [9:0] addr, input logic [7:0] wd, input logic done,
                             input logic err, input logic [1:0] code, input logic [10:0] cnt);
        logic [35:0] act;
        logic [35:0] exp;
        act = {ld_ready, wr_en, wen ? wr_addr : 10'd0, wen ? wr_data : 8'd0, load_done,
               load_err, err_code, cpu_stall, byte_cnt};
        exp = {rdy, wen, wen ? addr : 10'd0, wen ? wd : 8'd0, done, err, code, ~done, cnt};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got rdy=%b wen=%b addr=%0d wd=%h done=%b err=%b code=%b stall=%b cnt=%0d ; want rdy=%b wen=%b addr=%0d wd=%h done=%b err=%b code=%b stall=%b cnt=%0d",
                     name, ld_ready, wr_en, wr_addr, wr_data, load_done, load_err, err_code,
                     cpu_stall, byte_cnt, rdy, wen, addr, wd, done, err, code, ~done, cnt);
        end
    endtask

    task automatic check_reset(input string name);
        logic [35:0] act;
        act = {ld_ready, wr_en, wr_addr, wr_data, load_done, load_err, err_code, cpu_stall,
               byte_cnt};
        checks++;
        if (act !== {1'b1, 1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 2'b00, 1'b1, 11'd0}) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act,
                     {1'b1, 1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 2'b00, 1'b1, 11'd0});
        end
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] d;
        int         nwr;

        // Good 3-byte frame, checksum 30^F2^0A = C8.
        add(0, 1, 8'h03, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 1, 8'h30, 1, 1, 0, 8'h30, 0, 0, 2'b00, 1);
        add(0, 1, 8'hF2, 1, 1, 1, 8'hF2, 0, 0, 2'b00, 2);
        add(0, 1, 8'h0A, 1, 1, 2, 8'h0A, 0, 0, 2'b00, 3);
        add(0, 1, 8'hC8, 0, 0, 0, 8'h00, 1, 0, 2'b00, 3);
        add(0, 1, 8'h55, 0, 0, 0, 8'h00, 1, 0, 2'b00, 3);
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        // Checksum mismatch: 10^20 = 30, sent 31.
        add(0, 1, 8'h02, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 1, 8'h10, 1, 1, 0, 8'h10, 0, 0, 2'b00, 1);
        add(0, 1, 8'h20, 1, 1, 1, 8'h20, 0, 0, 2'b00, 2);
        add(0, 1, 8'h31, 0, 0, 0, 8'h00, 0, 1, 2'b10, 2);
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        // Length 1025: error, no writes, then re-arm.
        add(0, 1, 8'h01, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 1, 8'h04, 0, 0, 0, 8'h00, 0, 1, 2'b01, 0);
        add(0, 1, 8'h77, 0, 0, 0, 8'h00, 0, 1, 2'b01, 0);
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        // 5-byte frame with stalls and a start pulse mid-frame; XOR = 11.
        add(0, 1, 8'h05, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 0, 8'hFF, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 1, 8'h11, 1, 1, 0, 8'h11, 0, 0, 2'b00, 1);
        add(0, 0, 8'hEE, 1, 0, 0, 8'h00, 0, 0, 2'b00, 1);
        add(1, 0, 8'hEE, 1, 0, 0, 8'h00, 0, 0, 2'b00, 1);
        add(0, 1, 8'h22, 1, 1, 1, 8'h22, 0, 0, 2'b00, 2);
        add(0, 1, 8'h33, 1, 1, 2, 8'h33, 0, 0, 2'b00, 3);
        add(0, 0, 8'h99, 1, 0, 0, 8'h00, 0, 0, 2'b00, 3);
        add(0, 1, 8'h44, 1, 1, 3, 8'h44, 0, 0, 2'b00, 4);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 4);
        add(0, 1, 8'h55, 1, 1, 4, 8'h55, 0, 0, 2'b00, 5);
        add(0, 0, 8'h11, 1, 0, 0, 8'h00, 0, 0, 2'b00, 5);
        add(0, 1, 8'h11, 0, 0, 0, 8'h00, 1, 0, 2'b00, 5);
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        // Empty frame, checksum 00.
        add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        add(0, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0, 2'b00, 0);
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);

        rst_n    = 1'b0;
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        #1;
        check_reset("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].v, tbl[i].d);
            check_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].wen, tbl[i].addr, tbl[i].wd,
                      tbl[i].done, tbl[i].err, tbl[i].code, tbl[i].cnt);
        end

        // Full-size frame: N = 1024, last write lands at 1023.
        step(0, 1, 8'h00);
        step(0, 1, 8'h04);
        check_out("full_hdr", 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        x   = 8'h00;
        nwr = 0;
        for (int i = 0; i < 1024; i++) begin
            d = 8'((i * 7 + 3) ^ (i >> 5));
            x = x ^ d;
            step(0, 1, d);
            if (wr_en === 1'b1) nwr++;
            if (i < 4 || i > 1019) begin
                check_out($sformatf("full_b%0d", i), 1, 1, 10'(i), d, 0, 0, 2'b00, 11'(i + 1));
            end
        end
        checks++;
        if (nwr != 1024) begin
            failures++;
            $display("FAIL full_wr_count: got %0d want 1024", nwr);
        end
        step(0, 1, x);
        check_out("full_done", 0, 0, 0, 8'h00, 1, 0, 2'b00, 1024);
        step(1, 0, 8'h00);
        check_out("full_rearm", 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);

        // Reset in the middle of a 4-byte payload, away from any clock edge.
        step(0, 1, 8'h04);
        step(0, 1, 8'h00);
        step(0, 1, 8'hAA);
        step(0, 1, 8'hBB);
        check_out("mid_before_rst", 1, 1, 1, 8'hBB, 0, 0, 2'b00, 2);
        ld_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        check_out("post_rst_hdr", 1, 0, 0, 8'h00, 0, 0, 2'b00, 0);
        step(0, 1, 8'hAB);
        check_out("post_rst_wr", 1, 1, 0, 8'hAB, 0, 0, 2'b00, 1);
        step(0, 1, 8'hAB);
        check_out("post_rst_done", 0, 0, 0, 8'h00, 1, 0, 2'b00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, instruction-memory size in bytes (addresses 0..MEM_BYTES-1).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  re-arm pulse, honoured only in DONE or ERR.
REQ-005 SHALL have port ld_valid_i  input  1  loader byte-stream valid.
REQ-006 SHALL have port ld_data_i  input  8  loader byte-stream data.
REQ-007 SHALL have port ld_ready_o  output  1  loader byte-stream ready.
REQ-008 SHALL have port wr_en_o  output  1  instruction-memory byte write enable.
REQ-009 SHALL have port wr_addr_o  output  10  instruction-memory byte address.
REQ-010 SHALL have port wr_data_o  output  8  instruction-memory byte data.
REQ-011 SHALL have port load_done_o  output  1  program loaded and checksum good.
REQ-012 SHALL have port load_err_o  output  1  load aborted.
REQ-013 SHALL have port err_code_o  output  2  00 none, 01 length too large, 10 checksum mismatch, 11 reserved.
REQ-014 SHALL have port cpu_stall_o  output  1  holds fetch/pipeline frozen; equals NOT load_done_o.
REQ-015 SHALL have port byte_cnt_o  output  11  payload bytes written so far.

Function
REQ-016 SHALL transfer a byte only on a cycle where ld_valid_i and ld_ready_o are both 1 (accept); ld_data_i SHALL be ignored on any other cycle.
REQ-017 SHALL implement states LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR; ld_ready_o SHALL be 1 in LEN_LO/LEN_HI/DATA/CSUM, 0 in DONE/ERR.
REQ-018 SHALL take stream frame: length low byte, length high byte (16-bit little-endian N), N payload bytes, one checksum byte.
REQ-019 SHALL, in LEN_LO, on accept latch low byte and go to LEN_HI.
REQ-020 SHALL, in LEN_HI, on accept form N and go to: ERR with err_code 01 if N > MEM_BYTES; CSUM if N == 0; otherwise DATA.
REQ-021 SHALL, in DATA, on each accept write the byte at address byte_cnt_o, XOR it into an 8-bit running checksum, increment byte_cnt_o, and go to CSUM on the accept that makes byte_cnt_o equal N.
REQ-022 SHALL present each write registered: wr_en_o=1 for exactly the one cycle after the accept, with wr_addr_o/wr_data_o valid that cycle; wr_en_o=0 otherwise.
REQ-023 SHALL sustain one payload byte per cycle when ld_valid_i is held high; a stalled stream (ld_valid_i=0) SHALL leave all state unchanged.
REQ-024 SHALL, in CSUM, on accept go to DONE if the byte equals the running XOR (0x00 for N == 0), else ERR with err_code 10.
REQ-025 SHALL assert load_done_o only in DONE and load_err_o only in ERR, both registered (asserted the cycle after the deciding accept).
REQ-026 SHALL never write on length-error; bytes already written before a checksum error remain in memory.
REQ-027 SHALL, on start_i in DONE or ERR, go to LEN_LO next cycle, clearing load_done_o, load_err_o, err_code_o, byte_cnt_o, checksum and N; start_i SHALL be ignored in other states.
REQ-028 SHALL treat N == MEM_BYTES as legal, last write at address MEM_BYTES-1; wr_addr_o SHALL never wrap.

Reset
REQ-029 SHALL, while rst_n_i=0 and independent of clk_i, force state LEN_LO, ld_ready_o=1, wr_en_o=0, wr_addr_o=0, wr_data_o=0, load_done_o=0, load_err_o=0, err_code_o=00, cpu_stall_o=1, byte_cnt_o=0, checksum and N = 0.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame; after release the next accepted byte is a length low byte.

Verification
REQ-031 SHALL pass: stream 03 00 30 F2 0A C8, valid held high -> writes (0,30),(1,F2),(2,0A) on consecutive cycles, load_done_o=1, cpu_stall_o=0, byte_cnt_o=3.
REQ-032 SHALL pass: stream 02 00 10 20 31 -> two writes, load_err_o=1, err_code_o=10, load_done_o=0.
REQ-033 SHALL pass: stream 01 04 (N=1025) -> no write, load_err_o=1, err_code_o=01, ld_ready_o=0; then start_i pulse -> LEN_LO, flags cleared, ld_ready_o=1.
REQ-034 SHALL pass: stream 00 00 00 -> no write, load_done_o=1; stream 00 04 + 1024 bytes + correct XOR -> last write addr 1023, load_done_o=1.
REQ-035 SHALL pass: ld_valid_i toggled randomly over a 5-byte frame -> writes identical to uninterrupted case, one per accept.
REQ-036 SHALL pass: rst_n_i pulled low after 2 payload bytes of N=4 -> outputs at REQ-029 values immediately; new frame 01 00 AB AB -> write (0,AB), load_done_o=1.
